// File: rtl/hall_position_tracker.sv
// hall_position_tracker
//   Rotor angular-position tracker. N active-low Hall sensors, equally spaced
//   around the turn, are synchronised and debounced. The measured
//   sensor-to-sensor period is split into 2^SLICE_BITS slices, and each slice
//   boundary produces a one-cycle position_sync pulse for the column readout.
//   A timeout drops lock and flags a stall.
//
//   Optional feature: define HALL_RESYNC_EN to realign slice_cnt to the
//   sensor that fired on every top while locked. Without it, slice_cnt
//   free-runs once locked.
//
// Ports
//   clk            system clock
//   nrst           asynchronous active-low reset
//   hall           raw sensor pins, active-low, asynchronous to clk
//   slice_cnt      current slice index within the turn
//   position_sync  one-cycle pulse at each slice boundary
//   locked         high while the FSM is in LOCKED
//   stalled        sticky timeout flag, cleared by the next accepted top
//   period         cycles between the last two accepted tops
//
// FSM states
//   state      | meaning
//   ST_IDLE    | no valid period; waiting for the first top
//   ST_MEASURE | one top seen; measuring the first full interval
//   ST_LOCKED  | slice generator running from the measured period
module hall_position_tracker #(
  parameter int N_SENSORS = 2,
  parameter int SLICE_BITS = 7,
  parameter int CNT_W = 32,
  parameter int DEBOUNCE = 4,
  parameter int unsigned TIMEOUT = 32'd67108864,
  localparam int SLICE_W = SLICE_BITS + $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [N_SENSORS-1:0] hall,
  output logic [SLICE_W-1:0]   slice_cnt,
  output logic                 position_sync,
  output logic                 locked,
  output logic                 stalled,
  output logic [CNT_W-1:0]     period
);

  localparam int IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_t;

  logic [N_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DB_W-1:0]      low_cnt_q [N_SENSORS];
  logic [DB_W-1:0]      low_cnt_d [N_SENSORS];
  logic [DB_W-1:0]      high_cnt_q [N_SENSORS];
  logic [DB_W-1:0]      high_cnt_d [N_SENSORS];
  logic                 armed_q, armed_d;
  logic                 top_q, top_d;
  logic [IDX_W-1:0]     top_idx_q, top_idx_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     slice_period_q, slice_period_d;
  logic [CNT_W-1:0]     slice_ctr_q, slice_ctr_d;
  logic [SLICE_W-1:0]   slice_cnt_q, slice_cnt_d;
  logic                 sync_out_q, sync_out_d;
  logic                 locked_q, locked_d;
  logic                 stalled_q, stalled_d;
  state_t               state_q, state_d;

  logic                 any_asserted, all_high;
  logic [IDX_W-1:0]     first_idx;
  logic [CNT_W-1:0]     period_div;
  logic                 timeout, slice_wrap;
  logic [SLICE_W-1:0]   reload_val;

  always_comb begin
    sync1_d = hall;
    sync2_d = sync1_q;
    any_asserted = 1'b0;
    all_high = 1'b1;
    first_idx = '0;
    // Walk downwards so the lowest asserted index is the one left in first_idx.
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (sync2_q[i]) begin
        low_cnt_d[i] = '0;
        high_cnt_d[i] = (high_cnt_q[i] == DB_MAX) ? DB_MAX : high_cnt_q[i] + DB_W'(1);
      end else begin
        high_cnt_d[i] = '0;
        low_cnt_d[i] = (low_cnt_q[i] == DB_MAX) ? DB_MAX : low_cnt_q[i] + DB_W'(1);
      end
      if (low_cnt_q[i] == DB_MAX) begin
        any_asserted = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (high_cnt_q[i] != DB_MAX) all_high = 1'b0;
    end

    // A top needs every sensor to have been released first, so a long
    // magnet dwell or overlapping sensors cannot fire twice.
    top_d = armed_q && any_asserted;
    armed_d = top_d ? 1'b0 : (all_high ? 1'b1 : armed_q);
    top_idx_d = top_d ? first_idx : top_idx_q;

    period_div = counter_q >> SLICE_BITS;
    counter_d = top_q ? CNT_W'(1) : counter_q + CNT_W'(1);
    period_d = top_q ? counter_q : period_q;
    slice_period_d = slice_period_q;
    if (top_q) slice_period_d = (period_div == '0) ? CNT_W'(1) : period_div;

    timeout = (counter_q == TO_LAST) && !top_q;
    // >= rather than == so a shortened slice_period wraps at once.
    slice_wrap = slice_ctr_q >= (slice_period_q - CNT_W'(1));
    reload_val = SLICE_W'(top_idx_q) << SLICE_BITS;

    state_d = state_q;
    slice_ctr_d = slice_ctr_q;
    slice_cnt_d = slice_cnt_q;
    sync_out_d = 1'b0;
    stalled_d = top_q ? 1'b0 : stalled_q;

    if (timeout) begin
      state_d = ST_IDLE;
      stalled_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (top_q) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (top_q) begin
            state_d = ST_LOCKED;
            slice_cnt_d = reload_val;
            slice_ctr_d = '0;
            sync_out_d = 1'b1;
          end
        end
        ST_LOCKED: begin
`ifdef HALL_RESYNC_EN
          // Realignment wins over a coincident wrap: one pulse, new phase.
          if (top_q) begin
            slice_cnt_d = reload_val;
            slice_ctr_d = '0;
            sync_out_d = 1'b1;
          end else if (slice_wrap) begin
            slice_ctr_d = '0;
            slice_cnt_d = slice_cnt_q + SLICE_W'(1);
            sync_out_d = 1'b1;
          end else begin
            slice_ctr_d = slice_ctr_q + CNT_W'(1);
          end
`else
          if (slice_wrap) begin
            slice_ctr_d = '0;
            slice_cnt_d = slice_cnt_q + SLICE_W'(1);
            sync_out_d = 1'b1;
          end else begin
            slice_ctr_d = slice_ctr_q + CNT_W'(1);
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      for (int i = 0; i < N_SENSORS; i++) begin
        low_cnt_q[i] <= '0;
        high_cnt_q[i] <= '0;
      end
      armed_q <= 1'b0;
      top_q <= 1'b0;
      top_idx_q <= '0;
      counter_q <= '0;
      period_q <= '0;
      slice_period_q <= '1;
      slice_ctr_q <= '0;
      slice_cnt_q <= '0;
      sync_out_q <= 1'b0;
      locked_q <= 1'b0;
      stalled_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      for (int i = 0; i < N_SENSORS; i++) begin
        low_cnt_q[i] <= low_cnt_d[i];
        high_cnt_q[i] <= high_cnt_d[i];
      end
      armed_q <= armed_d;
      top_q <= top_d;
      top_idx_q <= top_idx_d;
      counter_q <= counter_d;
      period_q <= period_d;
      slice_period_q <= slice_period_d;
      slice_ctr_q <= slice_ctr_d;
      slice_cnt_q <= slice_cnt_d;
      sync_out_q <= sync_out_d;
      locked_q <= locked_d;
      stalled_q <= stalled_d;
      state_q <= state_d;
    end
  end

  assign slice_cnt = slice_cnt_q;
  assign position_sync = sync_out_q;
  assign locked = locked_q;
  assign stalled = stalled_q;
  assign period = period_q;

endmodule

// File: tb/tb_hall_position_tracker.sv
module tb_hall_position_tracker;
  localparam int N = 2;
  localparam int SB = 7;
  localparam int CW = 32;
  localparam int DB = 4;
  localparam int TO = 3000;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic [N-1:0]  hall = '1;
  logic [SW-1:0] slice_cnt;
  logic          position_sync, locked, stalled;
  logic [CW-1:0] period;

  hall_position_tracker #(
    .N_SENSORS(N), .SLICE_BITS(SB), .CNT_W(CW), .DEBOUNCE(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .nrst(nrst), .hall(hall), .slice_cnt(slice_cnt),
    .position_sync(position_sync), .locked(locked), .stalled(stalled), .period(period)
  );

  always #5 clk = ~clk;

  // Cycle n = values seen after the n-th rising edge since reset release.
  int cyc;
  always @(posedge clk or negedge nrst)
    if (!nrst) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct { int cyc; int slice; } pulse_t;
  typedef struct { int cyc; int per; bit lk; bit st; } stat_t;
  pulse_t pq[$];
  stat_t  sq[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  // Phase plan: top cycle, sensor mask, low width, extra low for sensor 1,
  // and whether a short glitch follows.
  int         top_t[$];
  logic [1:0] top_m[$];
  int         top_w[$];
  int         top_x[$];
  bit         top_g[$];
  int         end_cyc;
  int         last_t;
  bit         alt;

  // Reference model state: pulse schedule of the slice generator.
  int m_np, m_ns, m_sp, m_last;

  task automatic emit_until(input int c);
    while (m_np <= c) begin
      pq.push_back('{m_np, m_ns});
      m_last = m_np;
      m_np = m_np + m_sp;
      m_ns = (m_ns + 1) % (1 << SW);
    end
  endtask

  task automatic model_phase();
    int mode = 0;  // 0 idle, 1 measure, 2 locked
    int ref_c = 0;
    int cur_per = 0;
    for (int k = 0; k < top_t.size(); k++) begin
      int t = top_t[k];
      int idx = top_m[k][0] ? 0 : 1;
      int per, nsp;
      if (t > ref_c + TO - 1) begin
        if (mode == 2) emit_until(ref_c + TO - 1);
        sq.push_back('{ref_c + TO, cur_per, 1'b0, 1'b1});
        mode = 0;
      end else if (mode == 2) begin
        emit_until(t);
      end
      per = t - ref_c;
      nsp = per >> SB;
      if (nsp < 1) nsp = 1;
      if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        mode = 2;
        m_np = t + 1; m_ns = idx << SB; m_sp = nsp;
      end else begin
`ifdef HALL_RESYNC_EN
        m_np = t + 1; m_ns = idx << SB; m_sp = nsp;
`else
        emit_until(t + 1);
        m_np = (t + 2 > m_last + nsp) ? t + 2 : m_last + nsp;
        m_sp = nsp;
`endif
      end
      cur_per = per;
      sq.push_back('{t + 1, per, mode == 2, 1'b0});
      ref_c = t;
    end
    if (end_cyc >= ref_c + TO) begin
      if (mode == 2) emit_until(ref_c + TO - 1);
      sq.push_back('{ref_c + TO, cur_per, 1'b0, 1'b1});
    end else if (mode == 2) begin
      emit_until(end_cyc);
    end
  endtask

  task automatic plan_clear();
    top_t.delete(); top_m.delete(); top_w.delete(); top_x.delete(); top_g.delete();
    last_t = 0;
    alt = 0;
  endtask

  // mode_sel: 0 alternate sensors, 1 both at once
  task automatic add_top(input int gap, input int both);
    if (gap >= 200 && top_g.size() > 0) top_g[top_g.size()-1] = 1'($urandom_range(0, 1));
    last_t = last_t + gap;
    top_t.push_back(last_t);
    if (both != 0) top_m.push_back(2'b11);
    else top_m.push_back(alt ? 2'b10 : 2'b01);
    alt = ~alt;
    top_w.push_back($urandom_range(5, 10));
    top_x.push_back((both != 0) ? $urandom_range(1, 4) : 0);
    top_g.push_back(1'b0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_phase();
    for (int k = 0; k < top_t.size(); k++) begin
      int e = top_t[k] - (DB + 2);
      int rel = e - 1 + top_w[k] + top_x[k];
      wait_cyc(e - 1);
      hall = hall & ~top_m[k];
      wait_cyc(e - 1 + top_w[k]);
      hall[0] = 1'b1;
      wait_cyc(rel);
      hall = '1;
      if (top_g[k]) begin
        int gs = $urandom_range(0, N - 1);
        int gl = $urandom_range(1, 3);
        wait_cyc(rel + 30);
        hall[gs] = 1'b0;
        wait_cyc(rel + 30 + gl);
        hall = '1;
      end
    end
    wait_cyc(end_cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missed_sync cyc=%0d got=0 exp=1 (slice %0d)", pq[0].cyc, pq[0].slice);
        void'(pq.pop_front());
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missed_status cyc=%0d", sq[0].cyc);
        void'(sq.pop_front());
      end
      if (position_sync) begin
        checks++;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
          if (int'(slice_cnt) != pq[0].slice) begin
            failures++;
            $display("FAIL sync_slice cyc=%0d got=%0d exp=%0d", cyc, slice_cnt, pq[0].slice);
          end
          void'(pq.pop_front());
        end else begin
          failures++;
          $display("FAIL unexpected_sync cyc=%0d got=1 exp=0", cyc);
        end
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        checks += 3;
        if (locked !== sq[0].lk) begin
          failures++;
          $display("FAIL locked cyc=%0d got=%0d exp=%0d", cyc, locked, sq[0].lk);
        end
        if (stalled !== sq[0].st) begin
          failures++;
          $display("FAIL stalled cyc=%0d got=%0d exp=%0d", cyc, stalled, sq[0].st);
        end
        if (int'(period) != sq[0].per) begin
          failures++;
          $display("FAIL period cyc=%0d got=%0d exp=%0d", cyc, period, sq[0].per);
        end
        void'(sq.pop_front());
      end
    end
  end

  task automatic check_zero(input string tag);
    checks++;
    if (slice_cnt !== '0 || position_sync !== 1'b0 || locked !== 1'b0 ||
        stalled !== 1'b0 || period !== '0) begin
      failures++;
      $display("FAIL %s got=slice %0d sync %0d locked %0d stalled %0d period %0d exp=all zero",
               tag, slice_cnt, position_sync, locked, stalled, period);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (pq.size() != 0 || sq.size() != 0) begin
      failures++;
      $display("FAIL %s pending got=%0d/%0d exp=0/0", tag, pq.size(), sq.size());
    end
  endtask

  initial begin
    #1 nrst = 1'b0;
    #1 check_zero("reset_values");
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    mon_en = 1'b1;

    // Phase 1: steady rotation, random speeds, simultaneous triggers,
    // speed step, stall and relock, overspeed; ends in a mid-run reset.
    plan_clear();
    add_top(36, 0);
    for (int i = 0; i < 5; i++) add_top(1280, 0);
    for (int i = 0; i < 10; i++) add_top($urandom_range(700, 2600), ($urandom_range(0, 3) == 0) ? 1 : 0);
    add_top(1280, 1);
    add_top(640, 0);
    add_top(640, 0);
    add_top(3500, 0);
    add_top(1280, 0);
    add_top(1280, 0);
    for (int i = 0; i < 6; i++) add_top(64, 0);
    end_cyc = last_t + 150;
    model_phase();
    drive_phase();
    #2;
    check_drained("phase1_drain");
    checks++;
    if (locked !== 1'b1 || position_sync !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_overspeed got=locked %0d sync %0d exp=1 1", locked, position_sync);
    end
    mon_en = 1'b0;
    nrst = 1'b0;
    #1 check_zero("async_reset");
    pq.delete(); sq.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mon_en = 1'b1;

    // Phase 2: relock from scratch after reset.
    plan_clear();
    add_top(40, 0);
    add_top(1280, 0);
    add_top(1280, 1);
    for (int i = 0; i < 3; i++) add_top($urandom_range(700, 2600), 0);
    end_cyc = last_t + 100;
    model_phase();
    drive_phase();
    #2;
    check_drained("phase2_drain");
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
